// File: rtl/sobel_edge_3x3.sv
// Purpose : 3x3 Sobel edge magnitude over a column stream (upper/centre/lower luma), control words passed through.
// Latency : a column's result is written after its right neighbour (or the line's control word) has been seen.
// Backpressure: one-word output register; no pop and no state change while that register cannot be freed.
//
// Ports:
//   clk, srst_n       clock, asynchronous active-low reset
//   duo/dco/dlo       upper/centre/lower column words from an FWFT FIFO, valid while empty=0
//   rd_en             pops one column (or one control word) from upstream
//   dout, wr_en, full result word and push strobe towards the downstream FIFO
module sobel_edge_3x3 (
    input  logic        clk,
    input  logic        srst_n,
    input  logic [31:0] duo,
    input  logic [31:0] dco,
    input  logic [31:0] dlo,
    input  logic        empty,
    output logic        rd_en,
    output logic [31:0] dout,
    output logic        wr_en,
    input  logic        full
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRIME = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_CTRL  = 3'd4;

    logic [2:0]  state;
    logic [7:0]  lu, lc, ll, cu, cc, cl, ru, rc, rl;
    logic [31:0] obuf;
    logic        ovld;

    logic        free;
    logic        head_ctrl;
    logic        head_pix;
    logic        pix_state;
    logic [7:0]  nru, nrc, nrl;
    logic [7:0]  mag;
    logic [31:0] pix_word;
    logic        unused_hi;

    // Only the luma byte of the upper/lower words carries information.
    assign unused_hi = ^{duo[31:8], dlo[31:8]};

    assign wr_en     = ovld & ~full;
    assign free      = ~ovld | wr_en;
    assign dout      = obuf;
    assign head_ctrl = ~empty & (dco[31:30] == 2'b11);
    assign head_pix  = ~empty & (dco[31:30] != 2'b11);
    assign pix_state = (state == S_IDLE) | (state == S_PRIME) | (state == S_RUN);

    // Pixels are popped in the streaming states; the control word is popped only
    // from CTRL, after the line's last pixel has been flushed out.
    assign rd_en = srst_n & free &
                   ((pix_state & head_pix) | ((state == S_CTRL) & head_ctrl));

    // New right column: the incoming pixel, or a replica of R at the line end.
    assign nru = (state == S_FLUSH) ? ru : duo[7:0];
    assign nrc = (state == S_FLUSH) ? rc : dco[7:0];
    assign nrl = (state == S_FLUSH) ? rl : dlo[7:0];

    function automatic logic [7:0] sobel_mag(
        input logic [7:0] a_u, input logic [7:0] a_c, input logic [7:0] a_l,
        input logic [7:0] b_u, input logic [7:0] b_l,
        input logic [7:0] c_u, input logic [7:0] c_c, input logic [7:0] c_l
    );
        logic [10:0] s_r, s_l, s_u, s_d, gx, gy, ax, ay;
        logic [11:0] m;
        s_r = {3'b0, c_u} + {2'b0, c_c, 1'b0} + {3'b0, c_l};
        s_l = {3'b0, a_u} + {2'b0, a_c, 1'b0} + {3'b0, a_l};
        s_u = {3'b0, a_u} + {2'b0, b_u, 1'b0} + {3'b0, c_u};
        s_d = {3'b0, a_l} + {2'b0, b_l, 1'b0} + {3'b0, c_l};
        gx  = s_r - s_l;
        gy  = s_u - s_d;
        ax  = gx[10] ? (~gx + 11'd1) : gx;
        ay  = gy[10] ? (~gy + 11'd1) : gy;
        m   = {1'b0, ax} + {1'b0, ay};
        return (m > 12'd255) ? 8'hFF : m[7:0];
    endfunction

    // Evaluated on the window as it will stand after the shift (L=C, C=R, R=new).
    assign mag      = sobel_mag(cu, cc, cl, ru, rl, nru, nrc, nrl);
    assign pix_word = {8'h00, mag, mag, mag};

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state <= S_IDLE;
            obuf  <= 32'h0;
            ovld  <= 1'b0;
            lu <= 8'h0; lc <= 8'h0; ll <= 8'h0;
            cu <= 8'h0; cc <= 8'h0; cl <= 8'h0;
            ru <= 8'h0; rc <= 8'h0; rl <= 8'h0;
        end else begin
            if (wr_en) ovld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd_en) begin
                        // Left-edge replicate: the first column fills the whole window.
                        lu <= duo[7:0]; lc <= dco[7:0]; ll <= dlo[7:0];
                        cu <= duo[7:0]; cc <= dco[7:0]; cl <= dlo[7:0];
                        ru <= duo[7:0]; rc <= dco[7:0]; rl <= dlo[7:0];
                        state <= S_PRIME;
                    end else if (head_ctrl && free) begin
                        state <= S_CTRL;
                    end
                end
                S_PRIME, S_RUN, S_FLUSH: begin
                    if (rd_en || (state == S_FLUSH && free)) begin
                        lu <= cu;  lc <= cc;  ll <= cl;
                        cu <= ru;  cc <= rc;  cl <= rl;
                        ru <= nru; rc <= nrc; rl <= nrl;
                        obuf  <= pix_word;
                        ovld  <= 1'b1;
                        state <= (state == S_FLUSH) ? S_CTRL : S_RUN;
                    end else if (state != S_FLUSH && head_ctrl && free) begin
                        state <= S_FLUSH;
                    end
                end
                S_CTRL: begin
                    if (rd_en) begin
                        obuf  <= dco;
                        ovld  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
